// File: rtl/loader_write_queue.sv
// rtl/loader_write_queue.sv - loader-to-SDRAM write FIFO issuing one write per clock-enable slot
module loader_write_queue #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CE_DIV = 4,
    parameter int SLOT   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_write,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       flush,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_data,
    output logic [$clog2(CE_DIV)-1:0]  ce_phase,
    output logic                       ce,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int PW = $clog2(CE_DIV);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop;
    logic              push;

    assign ce    = (ce_phase == PW'(SLOT));
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Pop looks only at the pre-push state, so a push on a ce cycle into an
    // empty queue waits for the next slot; a full queue still accepts a push
    // on a cycle that pops.
    assign pop  = ce && !empty && !flush;
    assign push = in_write && !flush && (!full || pop);

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ce_phase  <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
        end else begin
            ce_phase <= ce_phase + PW'(1);
            if (flush) begin
                count     <= '0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                overflow  <= 1'b0;
                mem_write <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr    <= rd_ptr + AW'(1);
                    mem_write <= 1'b1;
                    mem_addr  <= addr_mem[rd_ptr];
                    mem_data  <= data_mem[rd_ptr];
                end else if (ce) begin
                    mem_write <= 1'b0;
                end
                count <= count + CW'(push) - CW'(pop);
                if (in_write && !push) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_loader_write_queue.sv
// tb/tb_loader_write_queue.sv - self-checking bench for loader_write_queue
module tb_loader_write_queue;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int CE_DIV = 4;
    localparam int SLOT   = 3;

    logic              clk = 1'b0;
    logic              reset, in_write, flush;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;

    logic              mem_write, ce, full, empty, overflow;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [1:0]        ce_phase;
    logic [3:0]        count;

    logic              m8_mem_write, m8_ce, m8_full, m8_empty, m8_overflow;
    logic [ADDR_W-1:0] m8_mem_addr;
    logic [DATA_W-1:0] m8_mem_data;
    logic [2:0]        m8_ce_phase;
    logic [3:0]        m8_count;

    always #5 clk = ~clk;

    loader_write_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
                         .CE_DIV(CE_DIV), .SLOT(SLOT)) dut (
        .clk(clk), .reset(reset), .in_write(in_write), .in_addr(in_addr),
        .in_data(in_data), .flush(flush), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_data(mem_data), .ce_phase(ce_phase),
        .ce(ce), .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    loader_write_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(8),
                         .CE_DIV(8), .SLOT(0)) dut8 (
        .clk(clk), .reset(reset), .in_write(in_write), .in_addr(in_addr),
        .in_data(in_data), .flush(flush), .mem_write(m8_mem_write),
        .mem_addr(m8_mem_addr), .mem_data(m8_mem_data), .ce_phase(m8_ce_phase),
        .ce(m8_ce), .count(m8_count), .full(m8_full), .empty(m8_empty),
        .overflow(m8_overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              mq[$];
    int                m_ph;
    bit                m_mw, m_ovf;
    logic [ADDR_W-1:0] m_ma;
    logic [DATA_W-1:0] m_md;
    logic [DATA_W-1:0] issued[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of pending writes and a phase counter; the write
    // register is reloaded only on a slot cycle.
    task automatic model_step();
        bit   ce_now, popped;
        int   sz;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_ph = 0; m_mw = 0; m_ovf = 0; m_ma = '0; m_md = '0;
            return;
        end
        ce_now = (m_ph == SLOT);
        sz     = mq.size();
        popped = ce_now && sz > 0;
        if (flush) begin
            mq.delete();
            m_ovf = 0;
            m_mw  = 0;
        end else begin
            if (popped) begin
                e = mq.pop_front();
                m_mw = 1; m_ma = e.a; m_md = e.d;
            end else if (ce_now) begin
                m_mw = 0;
            end
            if (in_write) begin
                if (sz < DEPTH || popped) mq.push_back('{in_addr, in_data});
                else m_ovf = 1;
            end
        end
        m_ph = (m_ph + 1) % CE_DIV;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model.mem_write", mem_write, m_mw);
        chk("model.mem_addr",  mem_addr,  m_ma);
        chk("model.mem_data",  mem_data,  m_md);
        chk("model.ce_phase",  ce_phase,  m_ph);
        chk("model.ce",        ce,        m_ph == SLOT);
        chk("model.count",     count,     mq.size());
        chk("model.full",      full,      mq.size() == DEPTH);
        chk("model.empty",     empty,     mq.size() == 0);
        chk("model.overflow",  overflow,  m_ovf);
        if (ce_phase == 2'((SLOT + 1) % CE_DIV) && mem_write === 1'b1)
            issued.push_back(mem_data);
    endtask

    task automatic set_in(input bit r, input bit f, input bit w,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        reset = r; flush = f; in_write = w; in_addr = a; in_data = d;
    endtask

    typedef struct {
        bit                rst;
        bit                w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bit                emw;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        int                eph;
        int                ecnt;
    } vec_t;

    vec_t vt[10];

    initial begin
        set_in(1, 0, 0, '0, '0);

        // Single write issued from the edge after phase 3, held four cycles
        vt[0] = '{1, 0, 22'h0,  8'h00, 0, 22'h0,  8'h00, 0, 0};
        vt[1] = '{0, 1, 22'h10, 8'hA5, 0, 22'h0,  8'h00, 1, 1};
        vt[2] = '{0, 0, 22'h0,  8'h00, 0, 22'h0,  8'h00, 2, 1};
        vt[3] = '{0, 0, 22'h0,  8'h00, 0, 22'h0,  8'h00, 3, 1};
        vt[4] = '{0, 0, 22'h0,  8'h00, 1, 22'h10, 8'hA5, 0, 0};
        vt[5] = '{0, 0, 22'h0,  8'h00, 1, 22'h10, 8'hA5, 1, 0};
        vt[6] = '{0, 0, 22'h0,  8'h00, 1, 22'h10, 8'hA5, 2, 0};
        vt[7] = '{0, 0, 22'h0,  8'h00, 1, 22'h10, 8'hA5, 3, 0};
        vt[8] = '{0, 0, 22'h0,  8'h00, 0, 22'h10, 8'hA5, 0, 0};
        vt[9] = '{0, 0, 22'h0,  8'h00, 0, 22'h10, 8'hA5, 1, 0};
        for (int i = 0; i < 10; i++) begin
            set_in(vt[i].rst, 0, vt[i].w, vt[i].a, vt[i].d);
            tick();
            chk("vec.mem_write", mem_write, vt[i].emw);
            chk("vec.mem_addr",  mem_addr,  vt[i].ea);
            chk("vec.mem_data",  mem_data,  vt[i].ed);
            chk("vec.ce_phase",  ce_phase,  vt[i].eph);
            chk("vec.count",     count,     vt[i].ecnt);
        end

        // Burst past full: the eleventh push (index 10) is the only one dropped
        set_in(1, 0, 0, '0, '0); tick();
        issued.delete();
        for (int i = 0; i < 12; i++) begin
            set_in(0, 0, 1, 22'h100 + 22'(i), 8'h40 + 8'(i)); tick();
        end
        chk("burst.count", count, 8);
        chk("burst.full", full, 1);
        chk("burst.overflow", overflow, 1);
        set_in(0, 0, 0, '0, '0);
        repeat (40) tick();
        chk("burst.issued_n", issued.size(), 11);
        for (int i = 0; i < 11 && i < issued.size(); i++)
            chk("burst.order", issued[i], 8'h40 + 8'((i < 10) ? i : 11));

        // Push while full on a slot cycle: accepted, no overflow, issued last
        set_in(1, 0, 0, '0, '0); tick();
        issued.delete();
        for (int i = 0; i < 10; i++) begin
            set_in(0, 0, 1, 22'h200 + 22'(i), 8'h60 + 8'(i)); tick();
        end
        chk("fullce.pre_count", count, 8);
        chk("fullce.pre_ovf", overflow, 0);
        set_in(0, 0, 0, '0, '0); tick();
        chk("fullce.is_ce", ce, 1);
        set_in(0, 0, 1, 22'h2EE, 8'hEE); tick();
        chk("fullce.count", count, 8);
        chk("fullce.overflow", overflow, 0);
        chk("fullce.full", full, 1);
        set_in(0, 0, 0, '0, '0);
        repeat (40) tick();
        chk("fullce.issued_n", issued.size(), 11);
        if (issued.size() > 0) chk("fullce.last", issued[issued.size()-1], 8'hEE);

        // Push into empty queue exactly on the slot: no bypass
        set_in(1, 0, 0, '0, '0); tick();
        set_in(0, 0, 0, '0, '0);
        repeat (3) tick();
        set_in(0, 0, 1, 22'h3C3, 8'h5A); tick();
        chk("nobypass.mw", mem_write, 0);
        chk("nobypass.count", count, 1);
        set_in(0, 0, 0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("nobypass.wait", mem_write, 0);
        end
        tick();
        chk("nobypass.issue", mem_write, 1);
        chk("nobypass.data", mem_data, 8'h5A);

        // Flush during a held write with three entries queued
        set_in(1, 0, 0, '0, '0); tick();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 1, 22'h400 + 22'(i), 8'h80 + 8'(i)); tick();
        end
        chk("flush.pre_mw", mem_write, 1);
        chk("flush.pre_count", count, 3);
        set_in(0, 1, 1, 22'h4FF, 8'hFF); tick();
        chk("flush.mw", mem_write, 0);
        chk("flush.count", count, 0);
        chk("flush.overflow", overflow, 0);
        chk("flush.phase", ce_phase, 1);
        set_in(0, 0, 0, '0, '0); tick();
        chk("flush.phase_next", ce_phase, 2);

        // CE_DIV=8, SLOT=0 instance: reset mid-burst, then a fresh push
        set_in(1, 0, 0, '0, '0); tick();
        for (int i = 0; i < 10; i++) begin
            set_in(0, 0, 1, 22'h500 + 22'(i), 8'h10 + 8'(i)); tick();
        end
        chk("d8.pre_mw", m8_mem_write, 1);
        set_in(1, 0, 1, 22'h5FF, 8'hFF); tick();
        chk("d8.rst_mw", m8_mem_write, 0);
        chk("d8.rst_addr", m8_mem_addr, 0);
        chk("d8.rst_data", m8_mem_data, 0);
        chk("d8.rst_phase", m8_ce_phase, 0);
        chk("d8.rst_count", m8_count, 0);
        chk("d8.rst_flags", {m8_empty, m8_full, m8_overflow}, 3'b100);
        set_in(0, 0, 0, '0, '0); tick();
        set_in(0, 0, 1, 22'h123, 8'h77); tick();
        set_in(0, 0, 0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            tick(); chk("d8.wait", m8_mem_write, 0);
        end
        tick();
        chk("d8.issue", m8_mem_write, 1);
        chk("d8.addr", m8_mem_addr, 22'h123);
        chk("d8.data", m8_mem_data, 8'h77);
        chk("d8.phase", m8_ce_phase, 1);

        // Randomized traffic against the reference queue
        set_in(1, 0, 0, '0, '0); tick();
        for (int i = 0; i < 1500; i++) begin
            set_in($urandom_range(0, 299) == 0, $urandom_range(0, 79) == 0,
                   $urandom_range(0, 99) < 55, ADDR_W'($urandom), DATA_W'($urandom));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
